// File: rtl/bf16_normalize_if.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_normalize_if
//  Description : Handshake bundle for the bf16_normalize stage. It carries the
//                upstream operand channel (valid_i/ready_o plus the
//                sign/exponent/mantissa triple) and the downstream result
//                channel (valid_o/ready_i plus the packed word and flags).
//                slave  : the normalizer itself
//                master : the environment around it (producer + consumer)
//  Ports       : valid_i, ready_o, sign_i, exp_i[E_W], mant_i[M_W],
//                valid_o, ready_i, data_o[16], ovf_o, sub_o
//  Revision    : 1.0  initial release
// ============================================================================
interface bf16_normalize_if #(
  parameter int M_W = 16,
  parameter int E_W = 8
);
  // Operand channel
  logic           valid_i;
  logic           ready_o;
  logic           sign_i;
  logic [E_W-1:0] exp_i;
  logic [M_W-1:0] mant_i;
  // Result channel
  logic           valid_o;
  logic           ready_i;
  logic [15:0]    data_o;
  logic           ovf_o;
  logic           sub_o;

  modport slave (
    input  valid_i, sign_i, exp_i, mant_i, ready_i,
    output ready_o, valid_o, data_o, ovf_o, sub_o
  );

  modport master (
    output valid_i, sign_i, exp_i, mant_i, ready_i,
    input  ready_o, valid_o, data_o, ovf_o, sub_o
  );
endinterface
`default_nettype wire

// File: rtl/bf16_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_normalize
//  Description : Two-stage normalize-and-round pipeline for the bfloat16
//                datapath. Stage 1 captures the raw sign/exponent/mantissa and
//                its leading-zero count; stage 2 shifts out the leading zeros
//                (clamped so the exponent never drops below 1, producing
//                subnormals), rounds to nearest-even and registers the packed
//                16-bit result together with overflow/subnormal flags.
//  Ports       : clk     - clock, all state on rising edge
//                nreset  - asynchronous active-low reset
//                bus     - bf16_normalize_if.slave (operand + result channels)
//  Revision    : 1.0  initial release
// ============================================================================
module bf16_normalize #(
  parameter int M_W = 16,
  parameter int E_W = 8
) (
  input  wire logic         clk,
  input  wire logic         nreset,
  bf16_normalize_if.slave   bus
);

  localparam int LZ_W  = $clog2(M_W + 1);
  localparam int F_W   = 7;
  // Comparison width wide enough for both the exponent and the lz count.
  localparam int CMP_W = ((E_W > LZ_W) ? E_W : LZ_W) + 1;
  localparam int R_W   = E_W + F_W + 1;

  // --------------------------------------------------------------------------
  // Handshake / advance logic
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv;
  logic s2_adv;

  always_comb begin
    s2_adv = !s2_valid_q || bus.ready_i;
    s1_adv = !s1_valid_q || s2_adv;
  end

  // No skid buffer: acceptance follows the downstream ready combinationally.
  assign bus.ready_o = s1_adv;

  // --------------------------------------------------------------------------
  // Leading-zero count of the incoming mantissa (all-zero gives M_W)
  // --------------------------------------------------------------------------
  logic [LZ_W-1:0] lz_in;

  always_comb begin
    lz_in = LZ_W'(M_W);
    // Scanning upward lets the most significant set bit win.
    for (int i = 0; i < M_W; i++) begin
      if (bus.mant_i[i]) begin
        lz_in = LZ_W'(M_W - 1 - i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic            s1_sign_q, s1_sign_d;
  logic [E_W-1:0]  s1_exp_q,  s1_exp_d;
  logic [M_W-1:0]  s1_mant_q, s1_mant_d;
  logic [LZ_W-1:0] s1_lz_q,   s1_lz_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_lz_d    = s1_lz_q;
    if (s1_adv) begin
      s1_valid_d = bus.valid_i;
      s1_sign_d  = bus.sign_i;
      s1_exp_d   = bus.exp_i;
      s1_mant_d  = bus.mant_i;
      s1_lz_d    = lz_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 datapath: shift, round, pack
  // --------------------------------------------------------------------------
  logic [CMP_W-1:0] exp_ext;
  logic [CMP_W-1:0] lz_ext;
  logic [CMP_W-1:0] exp_m1;
  logic             exp_zero;
  logic             exp_max;
  logic [LZ_W-1:0]  sh;
  logic [M_W-1:0]   n;
  logic [F_W-1:0]   frac;
  logic             guard;
  logic             sticky;
  logic             lsb;
  logic             round_up;
  logic             subn;
  logic [E_W-1:0]   exp_field;
  logic [R_W-1:0]   rsum;
  logic [E_W-1:0]   r_exp;
  logic [F_W-1:0]   r_frac;
  logic [15:0]      res_data;
  logic             res_ovf;
  logic             res_sub;

  always_comb begin
    exp_ext  = CMP_W'(s1_exp_q);
    lz_ext   = CMP_W'(s1_lz_q);
    exp_m1   = exp_ext - CMP_W'(1);
    exp_zero = (s1_exp_q == '0);
    exp_max  = &s1_exp_q;

    // Shift is limited so the result exponent stays >= 1; anything the
    // clamp leaves unshifted is expressed as a subnormal.
    if (exp_zero) begin
      sh = '0;
    end else if (lz_ext <= exp_m1) begin
      sh = s1_lz_q;
    end else begin
      sh = LZ_W'(exp_m1);
    end

    n        = s1_mant_q << sh;
    frac     = n[M_W-2 -: F_W];
    lsb      = n[M_W-1-F_W];
    guard    = n[M_W-2-F_W];
    sticky   = |n[M_W-3-F_W:0];
    round_up = guard & (sticky | lsb);

    // A clamped shift leaves the hidden-bit position empty; exponent 0
    // operands are taken as subnormal as they stand.
    subn      = exp_zero || !n[M_W-1];
    exp_field = subn ? '0 : (s1_exp_q - E_W'(sh));

    // Rounding on the joined {exponent, fraction} lets a fraction carry bump
    // the exponent and lets a subnormal round up into the normal range.
    rsum   = {1'b0, exp_field, frac} + R_W'(round_up);
    r_exp  = rsum[E_W+F_W-1:F_W];
    r_frac = rsum[F_W-1:0];

    res_data = '0;
    res_ovf  = 1'b0;
    res_sub  = 1'b0;
    if (s1_mant_q == '0) begin
      res_data = {s1_sign_q, 15'b0};
    end else if (exp_max || rsum[R_W-1] || (&r_exp)) begin
      res_data = {s1_sign_q, {E_W{1'b1}}, {F_W{1'b0}}};
      res_ovf  = 1'b1;
    end else begin
      res_data = {s1_sign_q, r_exp, r_frac};
      res_sub  = (r_exp == '0) && (r_frac != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 registers
  // --------------------------------------------------------------------------
  logic [15:0] data_q, data_d;
  logic        ovf_q,  ovf_d;
  logic        sub_q,  sub_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    sub_d      = sub_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      // Clear the payload on a bubble so flags never linger without valid.
      data_d     = s1_valid_q ? res_data : '0;
      ovf_d      = s1_valid_q & res_ovf;
      sub_d      = s1_valid_q & res_sub;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      sub_q      <= sub_d;
    end
  end

  assign bus.valid_o = s2_valid_q;
  assign bus.data_o  = data_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.sub_o   = sub_q;

endmodule
`default_nettype wire

// File: tb/tb_bf16_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf16_normalize
//  Description : Self-checking bench for bf16_normalize. Expected results
//                {data, ovf, sub} are queued as operands are driven and
//                compared as results leave the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bf16_normalize;

  localparam int M_W = 16;
  localparam int E_W = 8;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  always #5 clk = ~clk;

  bf16_normalize_if #(.M_W(M_W), .E_W(E_W)) bus ();

  bf16_normalize #(.M_W(M_W), .E_W(E_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          out_count = 0;
  logic [17:0] exp_q[$];

  // Scoreboard: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (nreset && bus.valid_o && bus.ready_i) begin
      n_tests++;
      out_count++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%h ovf=%b sub=%b, required no output",
                 bus.data_o, bus.ovf_o, bus.sub_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.data_o, bus.ovf_o, bus.sub_o} !== e) begin
          n_fail++;
          $display("FAIL result: got data=%h ovf=%b sub=%b, required data=%h ovf=%b sub=%b",
                   bus.data_o, bus.ovf_o, bus.sub_o, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  // Drive one operand and hold it until accepted; returns at edge+1.
  task automatic send(input logic s, input logic [7:0] e, input logic [15:0] m,
                      input logic [17:0] expv);
    bit acc;
    bus.valid_i = 1'b1;
    bus.sign_i  = s;
    bus.exp_i   = e;
    bus.mant_i  = m;
    exp_q.push_back(expv);
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready_o=0 for 50 cycles, required acceptance");
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({bus.valid_o, bus.data_o, bus.ovf_o, bus.sub_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h ovf=%b sub=%b, required all 0",
               bus.valid_o, bus.data_o, bus.ovf_o, bus.sub_o);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    #1;
    n_tests++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready_o=%b valid_o=%b, required 1 0",
               bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_basic();
    bit ok;
    send(1'b0, 8'h7F, 16'h8000, {16'h3F80, 2'b00});
    n_tests++;
    if (bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got valid_o=%b one cycle after transfer, required 0", bus.valid_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_2: got valid_o=%b two cycles after transfer, required 1", bus.valid_o);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_basic: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_shift();
    bit ok;
    send(1'b0, 8'h80, 16'h0100, {16'h3C80, 2'b00});
    send(1'b1, 8'h55, 16'h0000, {16'h8000, 2'b00});
    drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_shift: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_round();
    bit ok;
    send(1'b0, 8'h7F, 16'h8180, {16'h3F82, 2'b00});
    send(1'b0, 8'h7F, 16'h8080, {16'h3F80, 2'b00});
    send(1'b0, 8'h7F, 16'h8081, {16'h3F81, 2'b00});
    drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_round: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_ovf_sub();
    bit ok;
    send(1'b0, 8'hFE, 16'hFF80, {16'h7F80, 2'b10});
    send(1'b0, 8'h02, 16'h0800, {16'h0010, 2'b01});
    send(1'b0, 8'h01, 16'h7FFF, {16'h0080, 2'b00});
    send(1'b1, 8'hFF, 16'h8000, {16'hFF80, 2'b10});
    drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_ovf_sub: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    int          c0;
    logic [7:0]  ve[5];
    logic [15:0] vm[5];
    logic [17:0] vx[5];
    ve = '{8'h7F, 8'h80, 8'h7F, 8'hFE, 8'h02};
    vm = '{16'h8000, 16'h0100, 16'h8180, 16'hFF80, 16'h0800};
    vx = '{{16'h3F80, 2'b00}, {16'h3C80, 2'b00}, {16'h3F82, 2'b00},
           {16'h7F80, 2'b10}, {16'h0010, 2'b01}};
    c0 = out_count;
    fork
      begin
        for (int i = 0; i < 5; i++) send(1'b0, ve[i], vm[i], vx[i]);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_tests++;
          if (bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready_o: got %b with both stages full, required 0", bus.ready_o);
          end
          @(posedge clk);
          #1;
          n_tests++;
          if (bus.valid_o !== 1'b1 || bus.data_o !== 16'h3F80) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=3f80",
                     bus.valid_o, bus.data_o);
          end
        end
        bus.ready_i = 1'b1;
      end
    join
    drain(ok);
    n_tests++;
    if (!ok || (out_count - c0) != 5) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results (%0d pending), required 5 (0 pending)",
               out_count - c0, exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    bit ok;
    int c0;
    send(1'b0, 8'h7F, 16'h8000, {16'h3F80, 2'b00});
    send(1'b0, 8'h80, 16'h0100, {16'h3C80, 2'b00});
    #2;
    nreset = 1'b0;
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=%h mid-cycle, required 0 0000",
               bus.valid_o, bus.data_o);
    end
    exp_q.delete();
    c0 = out_count;
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%b ready=%b, required 0 1",
               bus.valid_o, bus.ready_o);
    end
    send(1'b0, 8'h7F, 16'h8180, {16'h3F82, 2'b00});
    n_tests++;
    if (bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_early: got valid_o=%b, required 0", bus.valid_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_latency: got valid_o=%b, required 1", bus.valid_o);
    end
    drain(ok);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (!ok || (out_count - c0) != 1) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d results, required 1", out_count - c0);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.exp_i   = '0;
    bus.mant_i  = '0;
    bus.ready_i = 1'b1;
    test_reset();
    test_basic();
    test_shift();
    test_round();
    test_ovf_sub();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bf16_normalize.md
Name: bf16_normalize

Overview:
- Pipelined normalize-and-round stage for the BFloat16 datapath; the consumer of the lzc leading-zero count.
- Takes an unnormalized sign/exponent/wide-mantissa triple from an adder or multiplier core.
- Left-shifts out the leading zeros and adjusts the exponent, with subnormal clamping.
- Rounds to nearest-even and emits a packed 16-bit bfloat16 word over a valid/ready handshake.

Parameters:
- M_W, 16: raw mantissa width; a power of 2, and at least 16. Bit M_W-1 is the hidden-bit position.
- E_W, 8: exponent width. Fixed to 8 for bfloat16; the parameter exists only for the bench.

Ports:
- clk  in  1  clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- valid_i  in  1  upstream operand valid
- ready_o  out  1  block can accept an operand this cycle
- sign_i  in  1  sign of result
- exp_i  in  E_W  biased exponent, valid when mant_i[M_W-1] is the hidden bit
- mant_i  in  M_W  unnormalized magnitude
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- data_o  out  16  packed bfloat16 {sign, exp[7:0], frac[6:0]}
- ovf_o  out  1  result overflowed to infinity
- sub_o  out  1  result is subnormal (exponent field 0, nonzero fraction)

Behaviour:
- Reset (async, nreset=0): valid_o=0, data_o=0, ovf_o=0, sub_o=0, all stage valid bits cleared. In-flight operands are dropped. ready_o=1 after release.
- Transfer rules: a transfer occurs on a cycle with valid && ready at each interface.
  - Upstream must hold its inputs stable while valid_i && !ready_o.
  - Outputs hold stable while valid_o && !ready_i.
- Pipeline: 2 stages, latency 2 cycles from input transfer to valid_o, throughput 1 per cycle.
  - Stage 1 (S1) registers sign, exp, mant and lz = lzc(mant_i), lz width clog2(M_W+1).
  - Stage 2 (S2) registers the packed result and flags.
- Backpressure:
  - s2_adv = !s2_valid || ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - ready_o = s1_adv, combinational from ready_i; no skid.
  - Each stage loads only on its advance; otherwise it holds. No loss, no duplication, order preserved.
- S2 shift amount:
  - mant==0: result {sign, 15'b0}, ovf=0, sub=0. Signed zero is preserved.
  - exp==0: sh=0; result is subnormal.
  - exp>=1: sh = min(lz, exp-1).
  - If sh<lz, or exp==0: exponent field = 0 and sub=1 if the fraction is nonzero. Otherwise exponent field = exp-sh.
- Rounding on n = mant<<sh:
  - frac = n[M_W-2:M_W-8]
  - guard = n[M_W-9]
  - sticky = |n[M_W-10:0]
  - lsb = n[M_W-8]
  - Round up iff guard && (sticky || lsb).
- Rounding carry: the increment is applied to the concatenated {exp_field, frac}.
  - Fraction carry increments the exponent.
  - A subnormal rounding up into exponent 1 becomes normal, with sub=0.
- Overflow: if the exponent field after rounding is 0xFF, or exp_i==0xFF, output {sign, 0xFF, 7'b0} with ovf=1. No NaN is generated.
- Flags are registered with data_o and valid only while valid_o=1.
- Simultaneous events:
  - S2 drains and S1 refills in the same cycle when ready_i=1 and valid_i=1.
  - Full pipeline with ready_i=0 gives ready_o=0.

Test Plan:
- sign 0, exp 0x7F, mant 0x8000 -> data_o 0x3F80, ovf 0, sub 0, valid_o exactly 2 cycles after the input transfer.
- exp 0x80, mant 0x0100 (lz=7) -> 0x3C80. Then mant 0x0000 with sign 1 -> 0x8000.
- Round-to-nearest-even on exp 0x7F:
  - mant 0x8180 (tie, odd lsb) -> 0x3F82.
  - mant 0x8080 (tie, even) -> 0x3F80.
  - mant 0x8081 (sticky) -> 0x3F81.
- Overflow and subnormal:
  - exp 0xFE, mant 0xFF80 -> 0x7F80, ovf 1.
  - exp 0x02, mant 0x0800 -> 0x0010, sub 1.
  - exp 0x01, mant 0x7FFF -> rounds to 0x0080, sub 0.
- Backpressure: stream 5 operands back-to-back, hold ready_i=0 for 3 cycles mid-stream.
  - ready_o falls when both stages are full.
  - data_o stays stable while stalled.
  - All 5 results arrive in order, none duplicated.
- Reset with 2 operands in flight: assert nreset=0 asynchronously mid-cycle -> valid_o=0 immediately. After release, the next operand produces exactly one result with latency 2.
